// File: rtl/clock_disp_scan_if.sv
// Time-value and display bus between the clock stages and the 7-segment scanner.
// The master drives the BCD time and the blink select; the slave drives the display pins.
interface clock_disp_scan_if;
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] am_pm;
    logic [1:0] blink_sel;
    logic [7:0] an;
    logic [6:0] segs_n;
    logic       dp_n;

    modport master (
        output h1, h0, m1, m0, s1, s0, am_pm, blink_sel,
        input  an, segs_n, dp_n
    );

    modport slave (
        input  h1, h0, m1, m0, s1, s0, am_pm, blink_sel,
        output an, segs_n, dp_n
    );
endinterface

// File: rtl/clock_disp_scan.sv
// 8-digit common-anode scanner for the lab clock: frame-consistent capture,
// blinking colon, hour leading-zero blanking and set-mode field blink.
module clock_disp_scan #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int DIGIT_HZ = 1000,
    parameter int BLINK_HZ = 1
) (
    input  logic               clk,
    input  logic               rst,
    clock_disp_scan_if.slave   bus
);
    localparam int DIV  = CLK_HZ / DIGIT_HZ;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW   = (DIV > 1)  ? $clog2(DIV)  : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blink_cnt;
    logic          tick;
    logic          blink_last;
    logic [2:0]    idx_p0;
    logic          started_p0;
    logic          blink_on_p0;
    logic [3:0]    sh_h1, sh_h0, sh_m1, sh_m0, sh_s1, sh_s0, sh_am_pm;

    logic [3:0]    digit_p0;
    logic          field_blank_p0;
    logic          colon_p0;

    logic [7:0]    an_p1;
    logic [6:0]    segs_n_p1;
    logic          dp_n_p1;

    assign tick       = (pre_cnt == PRE_LAST);
    assign blink_last = (blink_cnt == BLINK_LAST);

    // Stage p0: prescaler, digit index, blink phase and frame shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            idx_p0      <= 3'd7;
            started_p0  <= 1'b0;
            blink_cnt   <= '0;
            blink_on_p0 <= 1'b1;
            sh_h1       <= 4'd0;
            sh_h0       <= 4'd0;
            sh_m1       <= 4'd0;
            sh_m0       <= 4'd0;
            sh_s1       <= 4'd0;
            sh_s0       <= 4'd0;
            sh_am_pm    <= 4'd10;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                idx_p0     <= idx_p0 + 3'd1;
                started_p0 <= 1'b1;
                // Frame start: latch every value at once so a frame never mixes old and new time
                if (idx_p0 == 3'd7) begin
                    sh_h1    <= bus.h1;
                    sh_h0    <= bus.h0;
                    sh_m1    <= bus.m1;
                    sh_m0    <= bus.m0;
                    sh_s1    <= bus.s1;
                    sh_s0    <= bus.s0;
                    sh_am_pm <= bus.am_pm;
                end
            end
            if (blink_last) begin
                blink_cnt   <= '0;
                blink_on_p0 <= ~blink_on_p0;
            end else begin
                blink_cnt   <= blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        digit_p0       = 4'hF;
        field_blank_p0 = 1'b0;
        case (idx_p0)
            3'd7:    digit_p0 = (sh_h1 == 4'd0) ? 4'hF : sh_h1;
            3'd6:    digit_p0 = sh_h0;
            3'd5:    digit_p0 = sh_m1;
            3'd4:    digit_p0 = sh_m0;
            3'd3:    digit_p0 = sh_s1;
            3'd2:    digit_p0 = sh_s0;
            3'd1:    digit_p0 = 4'hF;
            default: digit_p0 = sh_am_pm;
        endcase
        // blink_sel is deliberately live so the set-mode UI responds within a digit
        if (!blink_on_p0) begin
            case (bus.blink_sel)
                2'd1:    field_blank_p0 = (idx_p0 == 3'd7) || (idx_p0 == 3'd6);
                2'd2:    field_blank_p0 = (idx_p0 == 3'd5) || (idx_p0 == 3'd4);
                2'd3:    field_blank_p0 = (idx_p0 == 3'd3) || (idx_p0 == 3'd2);
                default: field_blank_p0 = 1'b0;
            endcase
        end
        colon_p0 = blink_on_p0 && ((idx_p0 == 3'd6) || (idx_p0 == 3'd4));
    end

    // Stage p1: registered display pins, one cycle behind the index
    always_ff @(posedge clk) begin
        if (rst || !started_p0) begin
            an_p1     <= 8'hFF;
            segs_n_p1 <= 7'h7F;
            dp_n_p1   <= 1'b1;
        end else begin
            an_p1     <= ~(8'd1 << idx_p0);
            segs_n_p1 <= field_blank_p0 ? 7'h7F : seg_decode(digit_p0);
            dp_n_p1   <= ~colon_p0;
        end
    end

    assign bus.an     = an_p1;
    assign bus.segs_n = segs_n_p1;
    assign bus.dp_n   = dp_n_p1;
endmodule

// File: tb/tb_clock_disp_scan.sv
// Directed bench for clock_disp_scan at DIV=10, HALF=100 with an expected-value scoreboard.
module tb_clock_disp_scan;
    logic clk;
    logic rst;
    clock_disp_scan_if bus();

    clock_disp_scan #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLINK_HZ(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         at;
        logic [7:0] an;
        logic [6:0] segs;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ecount = 0;

    function automatic logic [6:0] seg(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic push(input string tag, input int at, input logic [7:0] an,
                        input logic [6:0] segs, input logic dp);
        exp_t e;
        e.tag = tag; e.at = at; e.an = an; e.segs = segs; e.dp = dp;
        sb.push_back(e);
    endtask

    // Advance to #1 after the n-th rising edge since the last reset release
    task automatic run_to(input int n);
        if (n > ecount) begin
            repeat (n - ecount) @(posedge clk);
            ecount = n;
            #1;
        end
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        ecount = 0;
    endtask

    task automatic drain_until(input int limit);
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= limit) begin
            e = sb.pop_front();
            run_to(e.at);
            checks++;
            assert ({bus.an, bus.segs_n, bus.dp_n} === {e.an, e.segs, e.dp})
            else begin
                errors++;
                $error("FAIL %s @%0d: an=%h segs_n=%b dp_n=%b, expected an=%h segs_n=%b dp_n=%b",
                       e.tag, e.at, bus.an, bus.segs_n, bus.dp_n, e.an, e.segs, e.dp);
            end
        end
    endtask

    task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                            input int s1, input int s0, input int ap);
        bus.h1 = 4'(h1); bus.h0 = 4'(h0);
        bus.m1 = 4'(m1); bus.m0 = 4'(m0);
        bus.s1 = 4'(s1); bus.s0 = 4'(s0);
        bus.am_pm = 4'(ap);
    endtask

    initial begin
        rst = 1'b1;
        bus.blink_sel = 2'd0;

        // Reset state, idle before first tick, first digit is AM
        set_time(0, 0, 0, 0, 0, 0, 10);
        pulse_reset(3);
        push("rst_hold",   0,  8'hFF, 7'h7F, 1'b1);
        push("idle_1",     1,  8'hFF, 7'h7F, 1'b1);
        push("idle_10",    10, 8'hFF, 7'h7F, 1'b1);
        push("first_am",   11, 8'hFE, seg(10), 1'b1);
        push("first_end",  20, 8'hFE, seg(10), 1'b1);
        push("zero_idx1",  21, 8'hFD, 7'h7F, 1'b1);
        push("zero_s0",    31, 8'hFB, seg(0), 1'b1);
        push("zero_h0",    71, 8'hBF, seg(0), 1'b0);
        push("zero_h1",    81, 8'h7F, 7'h7F, 1'b1);
        drain_until(1000);

        // Full frame of 1,2:3,4:5,6 PM, with m0 changed mid-frame at idx 3
        set_time(1, 2, 3, 4, 5, 6, 11);
        pulse_reset(1);
        push("f_idx0", 11, 8'hFE, seg(11), 1'b1);
        push("f_idx1", 21, 8'hFD, 7'h7F,   1'b1);
        push("f_s0",   31, 8'hFB, seg(6),  1'b1);
        push("f_s1",   41, 8'hF7, seg(5),  1'b1);
        push("f_m0",   51, 8'hEF, seg(4),  1'b0);
        push("f_m1",   61, 8'hDF, seg(3),  1'b1);
        push("f_h0",   71, 8'hBF, seg(2),  1'b0);
        push("f_h1",   81, 8'h7F, seg(1),  1'b1);
        drain_until(41);
        run_to(42);
        bus.m0 = 4'd7;
        push("m0_next_frame", 131, 8'hEF, seg(7), 1'b1);
        drain_until(1000);

        // Leading-zero blanking of hour tens
        set_time(0, 9, 3, 4, 5, 6, 10);
        pulse_reset(1);
        push("lz_h0", 71, 8'hBF, seg(9), 1'b0);
        push("lz_h1", 81, 8'h7F, 7'h7F,  1'b1);
        drain_until(1000);

        // Minutes blink, then live switch to hours blink
        set_time(1, 2, 3, 4, 5, 6, 11);
        bus.blink_sel = 2'd2;
        pulse_reset(1);
        push("bl_m0_on",   51,  8'hEF, seg(4), 1'b0);
        push("bl_m1_on",   61,  8'hDF, seg(3), 1'b1);
        push("bl_s1_off",  121, 8'hF7, seg(5), 1'b1);
        push("bl_m0_off",  131, 8'hEF, 7'h7F,  1'b1);
        push("bl_m1_off",  141, 8'hDF, 7'h7F,  1'b1);
        drain_until(1000);
        bus.blink_sel = 2'd1;
        push("bl_h0_off",  151, 8'hBF, 7'h7F,  1'b1);
        push("bl_h1_off",  161, 8'h7F, 7'h7F,  1'b1);
        push("bl_pm",      171, 8'hFE, seg(11), 1'b1);
        push("bl_m0_back", 211, 8'hEF, seg(4), 1'b0);
        push("bl_h0_back", 231, 8'hBF, seg(2), 1'b0);
        drain_until(1000);
        bus.blink_sel = 2'd0;

        // Reset asserted for one cycle while idx = 5
        pulse_reset(1);
        push("mid_m1", 61, 8'hDF, seg(3), 1'b1);
        drain_until(1000);
        run_to(62);
        pulse_reset(1);
        push("mid_rst",     0,  8'hFF, 7'h7F,  1'b1);
        push("mid_idle10",  10, 8'hFF, 7'h7F,  1'b1);
        push("mid_restart", 11, 8'hFE, seg(11), 1'b1);
        drain_until(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
